// File: rtl/digit_link_pkg.sv
// Shared constants and types for the serial 7-segment digit link.
// A digit travels LSB first as {dp, led[6:0]}, so the decimal point is the
// last bit on the wire and lands in bit DP_BIT of the reassembled byte.
package digit_link_pkg;
    localparam int DIGIT_W  = 8;
    localparam int LED_W    = 7;
    localparam int BITCNT_W = 3;
    localparam int DP_BIT   = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/digit_deserializer.sv
// Shift-in register plus bit counter for one serial digit.
// byte_val is the digit as it will look after the current sample is taken,
// so the parent can capture a finished digit on the same edge that samples
// its last bit. byte_done flags that edge; both are internal combinational
// signals and the parent registers everything it drives out.
// Only the upper seven bits of the shift register are kept: the oldest
// stored bit is never needed because the completed digit is taken from
// byte_val, which still contains it.
module digit_deserializer
    import digit_link_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               restart,
    input  logic               serial_in,
    output logic [DIGIT_W-1:0] byte_val,
    output logic               byte_done
);

    logic [DIGIT_W-1:1]  sr_reg;
    logic [BITCNT_W-1:0] bit_cnt_reg;

    assign byte_val  = {serial_in, sr_reg};
    assign byte_done = en & ~restart & (bit_cnt_reg == BITCNT_W'(DIGIT_W - 1));

    // Shift right on every qualified sample; restart makes this sample bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
        end else if (en) begin
            sr_reg <= byte_val[DIGIT_W-1:1];
            if (restart) begin
                bit_cnt_reg <= BITCNT_W'(1);
            end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/digit_shift_receiver.sv
// Receiving end of the serial 7-segment digit link: reassembles LSB-first
// digits and stores NUM_DIGITS of them per frame, starting at a start strobe.
// Optional build macro: DIGIT_SHIFT_RX_FRAME_ERR_EN enables the frame_err
// pulse for resyncs that cut a frame short; otherwise frame_err is tied low.
module digit_shift_receiver
    import digit_link_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          start,
    input  logic                          serial_in,
    output logic [LED_W-1:0]              led_out,
    output logic                          dp_out,
    output logic [IDX_W-1:0]              digit_idx,
    output logic                          digit_valid,
    output logic                          frame_done,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic                          frame_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [IDX_W-1:0]   wr_idx_reg;
    logic [DIGIT_W-1:0] slot_reg [NUM_DIGITS];
    logic               des_en;
    logic               des_restart;
    logic [DIGIT_W-1:0] byte_val;
    logic               byte_done;
    logic               last_digit;

    // In IDLE only a qualified start is accepted; in SHIFT every strobe counts.
    assign des_en      = en & ((state_reg == SHIFT) | start);
    assign des_restart = en & start;
    assign last_digit  = (wr_idx_reg == LAST_IDX);

    digit_deserializer u_deser (
        .clk       (clk),
        .reset     (reset),
        .en        (des_en),
        .restart   (des_restart),
        .serial_in (serial_in),
        .byte_val  (byte_val),
        .byte_done (byte_done)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: enter on start, leave once the last slot of the frame fills.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (en && start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (byte_done && last_digit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Write index, frame buffer and registered digit outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx_reg  <= '0;
            led_out     <= '0;
            dp_out      <= 1'b0;
            digit_idx   <= '0;
            digit_valid <= 1'b0;
            frame_done  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            digit_valid <= byte_done;
            frame_done  <= byte_done & last_digit;
            if (des_restart) begin
                wr_idx_reg <= '0;
            end else if (byte_done) begin
                wr_idx_reg <= last_digit ? '0 : wr_idx_reg + 1'b1;
            end
            if (byte_done) begin
                led_out   <= byte_val[LED_W-1:0];
                dp_out    <= byte_val[DP_BIT];
                digit_idx <= wr_idx_reg;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (byte_done && (wr_idx_reg == IDX_W'(i))) begin
                    slot_reg[i] <= byte_val;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            assign digits[gi*DIGIT_W +: DIGIT_W] = slot_reg[gi];
        end
    endgenerate

`ifdef DIGIT_SHIFT_RX_FRAME_ERR_EN
    // Any qualified start seen in SHIFT means the frame in progress never
    // finished: either a digit was cut mid-way or fewer than NUM_DIGITS
    // digits arrived before the next sync.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= (state_reg == SHIFT) & en & start;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_digit_shift_receiver.sv
// Bench for digit_shift_receiver: two instances (4 digits and 1 digit) share
// one serial stream. A bit-collecting reference model pushes expected digit
// events into per-instance queues; a negedge monitor pops and compares.
module tb_digit_shift_receiver;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic start;
    logic serial_in;

    logic [6:0]  d0_led;
    logic        d0_dp;
    logic [2:0]  d0_idx;
    logic        d0_valid;
    logic        d0_fd;
    logic [31:0] d0_digits;
    logic        d0_err;

    logic [6:0]  d1_led;
    logic        d1_dp;
    logic [0:0]  d1_idx;
    logic        d1_valid;
    logic        d1_fd;
    logic [7:0]  d1_digits;
    logic        d1_err;

    always #5 clk = ~clk;

    digit_shift_receiver #(.NUM_DIGITS(4), .IDX_W(3)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .start(start), .serial_in(serial_in),
        .led_out(d0_led), .dp_out(d0_dp), .digit_idx(d0_idx),
        .digit_valid(d0_valid), .frame_done(d0_fd), .digits(d0_digits),
        .frame_err(d0_err)
    );

    digit_shift_receiver #(.NUM_DIGITS(1), .IDX_W(1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .start(start), .serial_in(serial_in),
        .led_out(d1_led), .dp_out(d1_dp), .digit_idx(d1_idx),
        .digit_valid(d1_valid), .frame_done(d1_fd), .digits(d1_digits),
        .frame_err(d1_err)
    );

    typedef struct {
        int          idx;
        int          val;
        bit          fd;
        logic [31:0] snap;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   err_pend [2];
    int   tests = 0;
    int   fails = 0;

    // Reference model: collect sampled bits until eight are in hand.
    bit          m_active [2];
    int          m_cnt    [2];
    int          m_acc    [2];
    int          m_idx    [2];
    logic [31:0] m_buf    [2];
    int          nd       [2] = '{4, 1};

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 1'b0;
            m_cnt[k]    = 0;
            m_acc[k]    = 0;
            m_idx[k]    = 0;
            m_buf[k]    = '0;
            err_pend[k] = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    task automatic model_sample(input int k, input bit st, input bit b);
        exp_t e;
        if (!m_active[k]) begin
            if (st) begin
                m_active[k] = 1'b1;
                m_cnt[k]    = 1;
                m_acc[k]    = int'(b);
                m_idx[k]    = 0;
            end
            return;
        end
        if (st) begin
`ifdef DIGIT_SHIFT_RX_FRAME_ERR_EN
            err_pend[k]++;
`endif
            m_cnt[k] = 1;
            m_acc[k] = int'(b);
            m_idx[k] = 0;
            return;
        end
        m_acc[k] = m_acc[k] + (int'(b) << m_cnt[k]);
        m_cnt[k]++;
        if (m_cnt[k] == 8) begin
            m_buf[k][m_idx[k]*8 +: 8] = 8'(m_acc[k]);
            e.idx  = m_idx[k];
            e.val  = m_acc[k];
            e.fd   = (m_idx[k] == nd[k] - 1);
            e.snap = m_buf[k];
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
            m_cnt[k] = 0;
            m_acc[k] = 0;
            if (e.fd) m_active[k] = 1'b0;
            else      m_idx[k]++;
        end
    endtask

    task automatic step(input bit e, input bit s, input bit b);
        en        = e;
        start     = s;
        serial_in = b;
        @(posedge clk);
        if (e && !reset) begin
            model_sample(0, s, b);
            model_sample(1, s, b);
        end
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit first, input bit toggle, input bit inject);
        bit s;
        for (int i = 0; i < 8; i++) begin
            if (toggle) step(1'b0, 1'($urandom % 2), 1'($urandom % 2));
            s = (first && i == 0) || (inject && $urandom_range(0, 30) == 0);
            step(1'b1, s, v[i]);
        end
    endtask

    task automatic send_frame(input logic [31:0] f, input bit toggle, input bit inject);
        for (int d = 0; d < 4; d++) begin
            send_byte(f[d*8 +: 8], d == 0, toggle, inject);
        end
    endtask

    // Monitor-side comparison for one instance.
    task automatic check_inst(input int k, input bit v, input bit fd, input bit fe,
                              input int idx, input logic [6:0] led, input bit dp,
                              input logic [31:0] dg);
        exp_t        e;
        logic [31:0] mask;
        logic [7:0]  got;
        mask = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        got  = {dp, led};
        if (v) begin
            tests++;
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                fails++;
                $display("FAIL unexpected_valid dut%0d: got idx=%0d byte=%02h, required no pulse", k, idx, got);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                if (idx != e.idx || got != e.val[7:0] || fd != e.fd || (dg & mask) != (e.snap & mask)) begin
                    fails++;
                    $display("FAIL digit dut%0d: got idx=%0d byte=%02h fd=%0b digits=%08h, required idx=%0d byte=%02h fd=%0b digits=%08h",
                             k, idx, got, fd, dg & mask, e.idx, e.val[7:0], e.fd, e.snap & mask);
                end
            end
        end else if (fd) begin
            tests++;
            fails++;
            $display("FAIL lone_frame_done dut%0d: got frame_done=1 with digit_valid=0, required 0", k);
        end
        if (fe) begin
            tests++;
            if (err_pend[k] > 0) begin
                err_pend[k]--;
            end else begin
                fails++;
                $display("FAIL frame_err dut%0d: got pulse, required none", k);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check_inst(0, d0_valid, d0_fd, d0_err, int'(d0_idx), d0_led, d0_dp, d0_digits);
            check_inst(1, d1_valid, d1_fd, d1_err, int'(d1_idx), d1_led, d1_dp, {24'h0, d1_digits});
        end
    end

    task automatic check_zero(input string tag);
        tests++;
        if ({d0_led, d0_dp, d0_idx, d0_valid, d0_fd, d0_err, d0_digits} != '0) begin
            fails++;
            $display("FAIL %s dut0: got led=%02h dp=%0b idx=%0d v=%0b fd=%0b err=%0b digits=%08h, required all 0",
                     tag, d0_led, d0_dp, d0_idx, d0_valid, d0_fd, d0_err, d0_digits);
        end
        tests++;
        if ({d1_led, d1_dp, d1_idx, d1_valid, d1_fd, d1_err, d1_digits} != '0) begin
            fails++;
            $display("FAIL %s dut1: got led=%02h dp=%0b idx=%0d v=%0b fd=%0b err=%0b digits=%02h, required all 0",
                     tag, d1_led, d1_dp, d1_idx, d1_valid, d1_fd, d1_err, d1_digits);
        end
    endtask

    // Drain, then confirm nothing is outstanding and buffers match the model.
    task automatic end_check(input string tag);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL %s missing_valid: got %0d/%0d digits outstanding, required 0/0", tag, q0.size(), q1.size());
        end
        tests++;
        if (err_pend[0] != 0 || err_pend[1] != 0) begin
            fails++;
            $display("FAIL %s missing_frame_err: got %0d/%0d outstanding, required 0/0", tag, err_pend[0], err_pend[1]);
        end
        tests++;
        if (d0_digits != m_buf[0] || d1_digits != m_buf[1][7:0]) begin
            fails++;
            $display("FAIL %s digits: got %08h/%02h, required %08h/%02h", tag, d0_digits, d1_digits, m_buf[0], m_buf[1][7:0]);
        end
        $display("[TB] scenario %s checked, digits %08h/%02h", tag, d0_digits, d1_digits);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; start = 1'b0; serial_in = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 check_zero("reset_state");
        @(negedge clk);
        reset = 1'b0;

        send_frame(32'h4F5B06BF, 1'b0, 1'b0);
        end_check("contiguous");

        send_frame(32'h4F5B06BF, 1'b1, 1'b0);
        end_check("en_toggle");

        send_byte(8'hAA, 1'b1, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'($urandom % 2));
        send_frame(32'h04030201, 1'b0, 1'b0);
        end_check("resync");

        send_frame($urandom, 1'b0, 1'b0);
        send_frame(32'h80808080, 1'b0, 1'b0);
        end_check("back_to_back");

        send_frame(32'hFFFFFFFF, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_zero("reset_midframe");
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
        end_check("after_reset_ignored");

        send_frame(32'h1122337F, 1'b0, 1'b0);
        end_check("single_digit_7f");

        for (int n = 0; n < 25; n++) begin
            send_frame($urandom, 1'($urandom % 2), 1'b1);
        end
        end_check("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/digit_shift_receiver.md
Name: digit_shift_receiver

Overview:
- Receiving end of the serial 7-segment digit link.
- Samples a serial stream sent LSB first, 8 bits per digit: led[0..6], then dp as the last bit.
- Reassembles each digit in parallel and stores NUM_DIGITS digits per frame.
- Used as the bench/loopback counterpart of the display shifter, and in a display-side controller that drives segment outputs from a serial link.

Parameters:
- NUM_DIGITS, 4: digits per frame. Legal range 1..8.
- IDX_W, 3: width of the digit index; must satisfy 2**IDX_W >= NUM_DIGITS.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  bit strobe; serial_in is sampled only on edges where en=1.
- start  in  1  frame sync; qualified by en; marks the cycle carrying bit 0 of digit 0.
- serial_in  in  1  serial data, LSB first.
- led_out  out  7  segments of the most recently completed digit.
- dp_out  out  1  decimal point of the most recently completed digit.
- digit_idx  out  IDX_W  index of the most recently completed digit.
- digit_valid  out  1  one-cycle pulse: a digit has completed.
- frame_done  out  1  one-cycle pulse: digit NUM_DIGITS-1 has completed.
- digits  out  8*NUM_DIGITS  frame buffer; slot k is bits [8k+7:8k] = {dp, led}.
- frame_err  out  1  framing-error pulse; see Optional Feature.

Behaviour:
- Reset: all registers and outputs go to 0 (led_out, dp_out, digit_idx, digit_valid, frame_done, digits, frame_err). Shift register, bit counter and write index also clear. State = IDLE.
- Shift register sr[7:0] shifts right: each en-qualified sample loads sr <= {serial_in, sr[7:1]}. After 8 samples, sr = {dp, led[6:0]}.
- IDLE:
  - en & start: sample bit 0, bit_cnt <= 1, wr_idx <= 0, go to SHIFT.
  - All other inputs are ignored.
- SHIFT, en=0: hold all state.
- SHIFT, en=1 & start=0: shift and increment bit_cnt.
- SHIFT, en=1 & start=0 & bit_cnt==7 (8th bit), on that edge:
  - digits slot wr_idx <= {serial_in, sr[7:1]}.
  - {dp_out, led_out} <= the same value; digit_idx <= wr_idx.
  - digit_valid <= 1.
  - bit_cnt <= 0.
  - If wr_idx == NUM_DIGITS-1: frame_done <= 1, go to IDLE. Otherwise wr_idx <= wr_idx + 1.
- SHIFT, en=1 & start=1: resynchronise.
  - The partial digit is discarded; it is never written.
  - Sample is bit 0 of digit 0: bit_cnt <= 1, wr_idx <= 0.
  - Already-completed slots keep their old contents until overwritten.
- start coinciding with the 8th bit: start wins. The digit is not completed and no pulses are issued.
- Pulses: digit_valid and frame_done are high for exactly one cycle after the completing edge, then return to 0.
- Latency: outputs are visible in the cycle after the edge that samples the last bit. No combinational path from inputs to outputs.
- Back-to-back frames: start may arrive on the first en cycle after frame_done. No dead cycles are required.
- Reset mid-frame: immediate clear, including the digits buffer.
- Wrap: wr_idx never exceeds NUM_DIGITS-1.

Optional Feature:
- Macro: DIGIT_SHIFT_RX_FRAME_ERR_EN.
- Defined: in SHIFT, en & start with bit_cnt != 0 (resync mid-digit) pulses frame_err for one cycle on the following cycle. A start with bit_cnt == 0 that arrives before the frame completes also pulses frame_err (short frame). Resync behaviour is otherwise unchanged.
- Undefined: frame_err is tied to 0, and no extra logic is built.

Decomposition:
- Package digit_link_pkg holds:
  - DIGIT_W = 8, LED_W = 7, BITCNT_W = 3.
  - State enum {IDLE, SHIFT}.
  - Bit-ordering constant DP_BIT = 7.
- One sub-module, digit_deserializer: 8-bit shift-in register plus 3-bit counter, with inputs en and restart and outputs byte and byte_done. The top level owns the FSM, write index and frame buffer.

Test Plan:
- Reset asserted mid-frame with digits = 0xFFFF_FFFF → all outputs read 0 immediately, state = IDLE, and a subsequent bit with start=0 is ignored.
- NUM_DIGITS=4; send bytes 0xBF, 0x06, 0x5B, 0x4F LSB first (0xBF = bits 1,1,1,1,1,1,0,1) with en continuously high → digits = 0x4F5B06BF. digit_valid pulses 4 times, with digit_idx 0..3; frame_done pulses once, in the same cycle as the 4th digit_valid.
- Same frame with en toggling 1-0-1-0 → identical digits. Pulses occur only after the en-qualified 8th bit.
- start re-asserted at bit 5 of digit 2, then a full new frame of 0x01,0x02,0x03,0x04 → digits = 0x04030201, no pulse for the aborted digit, and frame_err pulses once when the macro is defined (stays 0 otherwise).
- Two frames back-to-back, second frame all 0x80 → digits = 0x80808080, dp_out=1, led_out=0x00, 2 frame_done pulses.
- NUM_DIGITS=1; send 0x7F → digit_valid and frame_done pulse together, digit_idx = 0, and the FSM returns to IDLE.
